// File: rtl/hazard_if.sv
// Decode-side hazard interface: D-stage instruction description in, stall/forward controls out.
// The decode stage uses the master view and hazard_ctl uses the slave view.
interface hazard_if #(
  parameter int AW   = 5,
  parameter int NSRC = 3,
  parameter int SW   = 3
);
  logic                 d_valid;
  logic [NSRC*AW-1:0]   d_src;
  logic [AW-1:0]        d_dst;
  logic [SW-1:0]        d_rdy;
  logic                 d_md_start;
  logic                 d_md_use;
  logic                 flush;
  logic                 stall;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 md_busy;
  logic [31:0]          stall_cnt;

  modport master (
    output d_valid, d_src, d_dst, d_rdy, d_md_start, d_md_use, flush,
    input  stall, fwd_sel, md_busy, stall_cnt
  );

  modport slave (
    input  d_valid, d_src, d_dst, d_rdy, d_md_start, d_md_use, flush,
    output stall, fwd_sel, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard/forwarding controller beside decode: tracks in-flight destinations, stalls D on RAW
// and mult/div hazards, and emits per-source forward selects aligned to the consuming stage.
module hazard_ctl #(
  parameter int              AW      = 5,
  parameter int              NSRC    = 3,
  parameter logic [2*NSRC-1:0] NEED  = {2'd2, 2'd1, 2'd0},
  parameter int              WB_SLOT = 3,
  parameter int              DEPTH   = 5,
  parameter int              SW      = 3,
  parameter int              MD_LAT  = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hif
);

  localparam int CW = $clog2(MD_LAT + 1);

  logic [AW-1:0]        slot_dst [1:DEPTH];
  logic [SW-1:0]        slot_rdy [1:DEPTH];
  logic [SW-1:0]        sel      [NSRC];
  logic [NSRC-1:0]      hit;
  logic [NSRC-1:0]      haz;
  logic                 raw_stall;
  logic                 md_stall;
  logic                 stall;
  logic                 bubble;
  logic                 md_issue;
  logic [CW-1:0]        md_cnt;
  logic                 md_busy;
  logic [31:0]          stall_cnt;
  logic [NSRC*SW-1:0]   fwd_sel;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Match each source against slots still ahead of the RF write; the nearest producer wins.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      hit[i] = 1'b0;
      haz[i] = 1'b0;
      sel[i] = '0;
      for (int k = 1; k < WB_SLOT; k++) begin
        if (!hit[i] && (hif.d_src[i*AW +: AW] != '0) &&
            (slot_dst[k] == hif.d_src[i*AW +: AW])) begin
          hit[i] = 1'b1;
          if (k + int'(NEED[2*i +: 2]) < int'(slot_rdy[k])) haz[i] = 1'b1;
          else                                              sel[i] = SW'(k + int'(NEED[2*i +: 2]));
        end
      end
    end
  end

  assign raw_stall = |haz;
  assign md_busy   = (md_cnt != '0);
  assign md_stall  = hif.d_valid & (hif.d_md_use | hif.d_md_start) & md_busy;
  assign stall     = !hif.flush & hif.d_valid & (raw_stall | md_stall);
  assign bubble    = stall | hif.flush | !hif.d_valid;
  assign md_issue  = hif.d_valid & hif.d_md_start & !stall & !hif.flush;

  // Slot 1 captures D (or a bubble); older slots always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        slot_dst[k] <= '0;
        slot_rdy[k] <= '0;
      end
    end else begin
      slot_dst[1] <= bubble ? '0 : hif.d_dst;
      slot_rdy[1] <= bubble ? '0 : hif.d_rdy;
      for (int k = 2; k <= DEPTH; k++) begin
        slot_dst[k] <= slot_dst[k-1];
        slot_rdy[k] <= slot_rdy[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (md_issue)            md_cnt <= CW'(MD_LAT);
      else if (md_cnt != '0)   md_cnt <= md_cnt - 1'b1;
      if (stall)               stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Per-source select delay: a select leaves the line when its instruction reaches stage NEED[i].
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    localparam int N = int'(NEED[2*i +: 2]);
    if (N == 0) begin : g_comb
      assign fwd_sel[i*SW +: SW] = sel[i];
    end else begin : g_dly
      logic [SW-1:0] sel_pipe [N];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < N; j++) sel_pipe[j] <= '0;
        end else begin
          sel_pipe[0] <= bubble ? '0 : sel[i];
          for (int j = 1; j < N; j++) sel_pipe[j] <= sel_pipe[j-1];
        end
      end
      assign fwd_sel[i*SW +: SW] = sel_pipe[N-1];
    end
  end

  assign hif.stall     = stall;
  assign hif.fwd_sel   = fwd_sel;
  assign hif.md_busy   = md_busy;
  assign hif.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: forwarding, load-use, branch, zero/nearest, mult/div, flush, reset.
module tb_hazard_ctl;
  localparam int AW = 5, NSRC = 3, SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  hazard_if #(.AW(AW), .NSRC(NSRC), .SW(SW)) hif ();

  hazard_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fsel(input int i);
    return 32'(hif.fwd_sel[i*SW +: SW]);
  endfunction

  task automatic drv(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                     input logic [AW-1:0] s2, input logic [AW-1:0] dst, input logic [SW-1:0] rdy,
                     input logic mds, input logic mdu, input logic fl);
    hif.d_valid    = v;
    hif.d_src      = {s2, s1, s0};
    hif.d_dst      = dst;
    hif.d_rdy      = rdy;
    hif.d_md_start = mds;
    hif.d_md_use   = mdu;
    hif.flush      = fl;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drain();
    idle();
    repeat (8) tick();
  endtask

  initial begin
    idle();
    #3;
    chk("rst_stall", 32'(hif.stall), 32'd0);
    chk("rst_busy", 32'(hif.md_busy), 32'd0);
    chk("rst_fwd", 32'(hif.fwd_sel), 32'd0);
    chk("rst_scnt", hif.stall_cnt, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // ALU -> ALU forwarding into E
    drv(1, 0, 0, 0, 5'd8, 3'd2, 0, 0, 0); settle();
    chk("alu_prod_stall", 32'(hif.stall), 32'd0);
    tick();
    drv(1, 0, 5'd8, 0, 0, 0, 0, 0, 0); settle();
    chk("alu_use_stall", 32'(hif.stall), 32'd0);
    tick();
    idle(); settle();
    chk("alu_fwd1", fsel(1), 32'd2);
    drain();

    // load-use: one stall then forward from slot 3
    drv(1, 0, 0, 0, 5'd9, 3'd3, 0, 0, 0); tick();
    drv(1, 0, 5'd9, 0, 0, 0, 0, 0, 0); settle();
    chk("ld_stall", 32'(hif.stall), 32'd1);
    tick(); settle();
    chk("ld_release", 32'(hif.stall), 32'd0);
    chk("ld_scnt", hif.stall_cnt, 32'd1);
    tick();
    idle(); settle();
    chk("ld_fwd1", fsel(1), 32'd3);
    drain();

    // branch in D after ALU
    drv(1, 0, 0, 0, 5'd4, 3'd2, 0, 0, 0); tick();
    drv(1, 5'd4, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("br_stall", 32'(hif.stall), 32'd1);
    tick(); settle();
    chk("br_release", 32'(hif.stall), 32'd0);
    chk("br_fwd0", fsel(0), 32'd2);
    chk("br_scnt", hif.stall_cnt, 32'd2);
    tick();
    drain();

    // zero register never matches
    drv(1, 0, 0, 0, 5'd0, 3'd3, 0, 0, 0); tick();
    drv(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0); settle();
    chk("zero_stall", 32'(hif.stall), 32'd0);
    chk("zero_fwd0", fsel(0), 32'd0);
    tick();
    drain();

    // same dst in slots 1 and 2: nearest (slot 1) wins
    drv(1, 0, 0, 0, 5'd7, 3'd2, 0, 0, 0); tick();
    drv(1, 0, 0, 0, 5'd7, 3'd2, 0, 0, 0); tick();
    drv(1, 0, 5'd7, 5'd7, 0, 0, 0, 0, 0); settle();
    chk("near_stall", 32'(hif.stall), 32'd0);
    tick();
    idle(); settle();
    chk("near_fwd1", fsel(1), 32'd2);
    tick(); settle();
    chk("near_fwd2", fsel(2), 32'd3);
    chk("near_fwd1_gone", fsel(1), 32'd0);
    drain();

    // flush during load-use hazard: no stall, bubble in slot 1 and delay line
    drv(1, 0, 0, 0, 5'd9, 3'd3, 0, 0, 0); tick();
    drv(1, 0, 5'd9, 0, 5'd12, 3'd2, 0, 0, 1); settle();
    chk("fl_stall", 32'(hif.stall), 32'd0);
    tick();
    drv(1, 5'd12, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("fl_bubble_stall", 32'(hif.stall), 32'd0);
    chk("fl_fwd1", fsel(1), 32'd0);
    chk("fl_scnt", hif.stall_cnt, 32'd2);
    tick();
    drain();

    // mult/div issue then dependent use
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0); settle();
    chk("md_issue_busy", 32'(hif.md_busy), 32'd0);
    chk("md_issue_stall", 32'(hif.stall), 32'd0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0); settle();
    chk("md_busy", 32'(hif.md_busy), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("md_stall", 32'(hif.stall), 32'd1);
      tick(); settle();
    end
    chk("md_release", 32'(hif.stall), 32'd0);
    chk("md_idle", 32'(hif.md_busy), 32'd0);
    chk("md_scnt", hif.stall_cnt, 32'd7);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0); settle();
    chk("md_reissue_busy", 32'(hif.md_busy), 32'd1);

    // async reset while mult/div busy
    rst_n = 1'b0; settle();
    chk("rst2_busy", 32'(hif.md_busy), 32'd0);
    chk("rst2_stall", 32'(hif.stall), 32'd0);
    chk("rst2_fwd", 32'(hif.fwd_sel), 32'd0);
    chk("rst2_scnt", hif.stall_cnt, 32'd0);
    idle();
    #2 rst_n = 1'b1;
    tick(); settle();
    chk("post_rst_busy", 32'(hif.md_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
